// File: rtl/param_cfg_pkg.sv
// Shared types and constants for the configuration sequencer and its watchdog.
package param_cfg_pkg;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_e;

  localparam int unsigned NUM_CFG_BYTES = 6;

  localparam logic [2:0] OFF_INT0  = 3'd0;
  localparam logic [2:0] OFF_INT1  = 3'd1;
  localparam logic [2:0] OFF_INT2  = 3'd2;
  localparam logic [2:0] OFF_INT3  = 3'd3;
  localparam logic [2:0] OFF_BIT   = 3'd4;
  localparam logic [2:0] OFF_LOGIC = 3'd5;

  typedef struct packed {
    logic [31:0] int_f;
    logic [7:0]  bit_f;
    logic [3:0]  logic_f;
  } cfg_rec_t;

  // Byte k of the result sits at bits [8k+7:8k]; int is little-endian at offset 0.
  function automatic logic [47:0] pack_bytes(input cfg_rec_t rec);
    return {4'b0000, rec.logic_f, rec.bit_f, rec.int_f};
  endfunction

endpackage

// File: rtl/param_cfg_sequencer_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and flags the one that reaches the limit.
module param_cfg_watchdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       stall,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (stall) begin
      count <= count + 8'd1;
    end
  end

  // Combinational so the owner can leave SEND on the very edge the count would reach limit.
  assign expired = stall && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/param_cfg_sequencer.sv
// Snapshots a typed config record on start and writes it out as six addressed bytes.
module param_cfg_sequencer
  import param_cfg_pkg::*;
#(
  parameter logic [31:0]  INT_INIT    = 32'd42,
  parameter logic [7:0]   BIT_INIT    = 8'hAB,
  parameter logic [3:0]   LOGIC_INIT  = 4'b1010,
  parameter logic [7:0]   BASE_ADDR   = 8'h00,
  parameter int unsigned  ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        override_en,
  input  logic [31:0] int_val,
  input  logic [7:0]  bit_val,
  input  logic [3:0]  logic_val,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam logic [7:0] LIMIT = ACK_TIMEOUT[7:0];

  state_e      state;
  logic [47:0] shadow;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  cfg_rec_t    sel_rec;
  logic [47:0] sel_bytes;
  logic        handshake;
  logic        stall;
  logic        wd_clr;
  logic        wd_expired;

  always_comb begin
    sel_rec = override_en ? '{int_f: int_val,  bit_f: bit_val,  logic_f: logic_val}
                          : '{int_f: INT_INIT, bit_f: BIT_INIT, logic_f: LOGIC_INIT};
  end

  assign sel_bytes = pack_bytes(sel_rec);
  assign handshake = wr_valid & wr_ready;
  assign stall     = wr_valid & ~wr_ready;
  assign wd_clr    = (state != SEND) | handshake;
  assign idx_nxt   = idx + 3'd1;

  param_cfg_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .stall   (stall),
    .limit   (LIMIT),
    .expired (wd_expired)
  );

  // Address/data are registered one step ahead so they stay frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow   <= sel_bytes;
            idx      <= OFF_INT0;
            error    <= 1'b0;
            busy     <= 1'b1;
            wr_valid <= 1'b1;
            wr_addr  <= BASE_ADDR;
            wr_data  <= sel_bytes[7:0];
            state    <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (idx == OFF_LOGIC) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              idx     <= idx_nxt;
              wr_addr <= BASE_ADDR + {5'b00000, idx_nxt};
              wr_data <= shadow[{idx_nxt, 3'b000} +: 8];
            end
          end else if (wd_expired) begin
            wr_valid <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cfg_sequencer.sv
// Directed bench: three sequencer instances cover default, short-timeout and wrapping-base builds.
module tb_param_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        override_en = 1'b0;
  logic [31:0] int_val = '0;
  logic [7:0]  bit_val = '0;
  logic [3:0]  logic_val = '0;

  logic       start0 = 1'b0, rdy0 = 1'b1;
  logic       busy0, done0, err0, val0;
  logic [7:0] addr0, data0;
  logic       start1 = 1'b0, rdy1 = 1'b1;
  logic       busy1, done1, err1, val1;
  logic [7:0] addr1, data1;
  logic       start2 = 1'b0, rdy2 = 1'b1;
  logic       busy2, done2, err2, val2;
  logic [7:0] addr2, data2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_cfg_sequencer d0 (
    .clk(clk), .rst(rst), .start(start0), .override_en(override_en),
    .int_val(int_val), .bit_val(bit_val), .logic_val(logic_val),
    .busy(busy0), .done(done0), .error(err0), .wr_valid(val0),
    .wr_ready(rdy0), .wr_addr(addr0), .wr_data(data0)
  );

  param_cfg_sequencer #(.ACK_TIMEOUT(4)) d1 (
    .clk(clk), .rst(rst), .start(start1), .override_en(override_en),
    .int_val(int_val), .bit_val(bit_val), .logic_val(logic_val),
    .busy(busy1), .done(done1), .error(err1), .wr_valid(val1),
    .wr_ready(rdy1), .wr_addr(addr1), .wr_data(data1)
  );

  param_cfg_sequencer #(.BASE_ADDR(8'hFE)) d2 (
    .clk(clk), .rst(rst), .start(start2), .override_en(override_en),
    .int_val(int_val), .bit_val(bit_val), .logic_val(logic_val),
    .busy(busy2), .done(done2), .error(err2), .wr_valid(val2),
    .wr_ready(rdy2), .wr_addr(addr2), .wr_data(data2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_def [6];
  logic [7:0] exp_ovr [6];
  logic [7:0] exp_wrap [6];
  logic [7:0] seen_addr [6];
  int hs;

  initial begin
    exp_def  = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hAB, 8'h0A};
    exp_ovr  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h05};
    exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_error", err0, 0);
    chk("rst_valid", val0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);

    // Default record, back-to-back
    override_en = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("def_valid%0d", k), val0, 1);
      chk($sformatf("def_addr%0d", k), addr0, k);
      chk($sformatf("def_data%0d", k), data0, exp_def[k]);
      chk($sformatf("def_done%0d", k), done0, 0);
      tick();
    end
    chk("def_fin_done", done0, 1);
    chk("def_fin_valid", val0, 0);
    chk("def_fin_error", err0, 0);
    chk("def_fin_busy", busy0, 1);
    tick();
    chk("def_idle_done", done0, 0);
    chk("def_idle_busy", busy0, 0);

    // Override record; inputs changed after the snapshot must not leak in
    override_en = 1'b1;
    int_val = 32'h1234_5678;
    bit_val = 8'hFF;
    logic_val = 4'h5;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    int_val = 32'hDEAD_BEEF;
    bit_val = 8'h11;
    logic_val = 4'hC;
    override_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ovr_addr%0d", k), addr0, k);
      chk($sformatf("ovr_data%0d", k), data0, exp_ovr[k]);
      tick();
    end
    chk("ovr_fin_done", done0, 1);
    tick();

    // Short stall on offset 2 holds address and data
    override_en = 1'b1;
    int_val = 32'h1234_5678;
    bit_val = 8'hFF;
    logic_val = 4'h5;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    rdy0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_valid%0d", c), val0, 1);
      chk($sformatf("stall_addr%0d", c), addr0, 8'h02);
      chk($sformatf("stall_data%0d", c), data0, 8'h34);
      tick();
    end
    rdy0 = 1'b1;
    chk("stall_rel_addr", addr0, 8'h02);
    chk("stall_rel_data", data0, 8'h34);
    for (int k = 3; k < 7; k++) begin
      tick();
      if (k < 6) chk($sformatf("stall_after%0d", k), data0, exp_ovr[k]);
    end
    chk("stall_fin_done", done0, 1);
    chk("stall_fin_error", err0, 0);
    tick();

    // Abort with ACK_TIMEOUT=4 while offset 1 is stalled
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    rdy1 = 1'b0;
    chk("abt_s_valid", val1, 1);
    chk("abt_s_addr", addr1, 8'h01);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk($sformatf("abt_wait_done%0d", c), done1, 0);
      chk($sformatf("abt_wait_valid%0d", c), val1, 1);
    end
    tick();
    chk("abt_done", done1, 1);
    chk("abt_error", err1, 1);
    chk("abt_valid", val1, 0);
    tick();
    chk("abt_idle_done", done1, 0);
    chk("abt_hold_err1", err1, 1);
    tick(); tick();
    chk("abt_hold_err2", err1, 1);
    rdy1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("abt_restart_err", err1, 0);
    chk("abt_restart_addr", addr1, 8'h00);
    repeat (6) tick();
    chk("abt_restart_done", done1, 1);
    chk("abt_restart_err2", err1, 0);
    tick();

    // Wrapping base address, starts during SEND and FIN ignored
    hs = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (val2 && rdy2) begin
        if (hs < 6) seen_addr[hs] = addr2;
        hs++;
      end
      start2 = (i == 2 || i == 6);
      tick();
    end
    start2 = 1'b0;
    chk("wrap_handshakes", hs, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("wrap_addr%0d", k), seen_addr[k], exp_wrap[k]);
    chk("wrap_idle_busy", busy2, 0);

    // Reset mid-sequence after the offset 2 handshake
    override_en = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick(); tick();
    chk("mid_addr3", addr0, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_error", err0, 0);
    chk("mid_rst_valid", val0, 0);
    chk("mid_rst_addr", addr0, 0);
    chk("mid_rst_data", data0, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fresh_addr%0d", k), addr0, k);
      chk($sformatf("fresh_data%0d", k), data0, exp_def[k]);
      tick();
    end
    chk("fresh_done", done0, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
